// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the funct3 decode used by the core to derive size/unsigned.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    return lsu_size_e'(f3[1:0]);
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replicated data, misalignment
// detection on the live request, and load extraction from the registered access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  always_comb begin
    o_be         = '0;
    o_wdata      = '0;
    o_misaligned = 1'b0;
    case (lsu_size_e'(i_size))
      SZ_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_store_data[7:0]}};
      end
      SZ_H: begin
        o_be         = 4'b0011 << i_off;
        o_wdata      = {2{i_store_data[15:0]}};
        o_misaligned = i_off[0];
      end
      SZ_W: begin
        o_be         = '1;
        o_wdata      = i_store_data;
        o_misaligned = |i_off;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

  // Word accesses are always at offset 0, so the shifted value is the raw word.
  assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_load_data = w_shifted;
    case (lsu_size_e'(i_ld_size))
      SZ_B:    o_load_data = {{24{~i_ld_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_load_data = {{16{~i_ld_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts a load/store from the ALU, runs one
// req/gnt/rvalid bus transaction and retires it with a one-cycle done pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [31:0] r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_unsigned;

  logic        w_accept;
  logic        w_complete;
  logic        w_expire;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic [31:0] w_load_fmt;

  lsu_align u_align (
    .i_size        (lsu_size),
    .i_off         (alu_result[1:0]),
    .i_store_data  (store_data),
    .o_be          (w_be),
    .o_wdata       (w_wdata),
    .o_misaligned  (w_misaligned),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_rdata       (dbus_rdata),
    .o_load_data   (w_load_fmt)
  );

  assign lsu_stall = lsu_req & ~lsu_done;
  assign w_accept  = (r_state == IDLE) & lsu_req & ~lsu_done;
  // Fires on the last allowed wait cycle so the counter "reaches" the limit at the edge.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);

  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    w_expire   = 1'b0;
    case (r_state)
      IDLE: if (w_accept && !w_misaligned) w_next = REQ;
      REQ: begin
        if (dbus_gnt) begin
          if (dbus_rvalid) begin
            w_next     = IDLE;
            w_complete = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dbus_rvalid) begin
          w_next     = IDLE;
          w_complete = 1'b1;
        end else if (w_timeout) begin
          w_next   = IDLE;
          w_expire = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_size     <= '0;
      r_off      <= '0;
      r_unsigned <= 1'b0;
      lsu_done   <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      load_data  <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
    end else begin
      r_state    <= w_next;
      lsu_done   <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      dbus_req   <= (w_next == REQ);

      if (w_accept) begin
        if (w_misaligned) begin
          lsu_done   <= 1'b1;
          misaligned <= 1'b1;
          load_data  <= '0;
        end else begin
          dbus_addr  <= {alu_result[31:2], 2'b00};
          dbus_be    <= w_be;
          dbus_wdata <= w_wdata;
          dbus_we    <= lsu_we;
          r_size     <= lsu_size;
          r_off      <= alu_result[1:0];
          r_unsigned <= lsu_unsigned;
        end
      end

      if (w_complete) begin
        lsu_done  <= 1'b1;
        load_data <= dbus_we ? '0 : w_load_fmt;
      end

      if (w_expire) begin
        lsu_done  <= 1'b1;
        bus_error <= 1'b1;
        load_data <= '0;
      end

      if (r_state == REQ && dbus_gnt) r_cnt <= '0;
      else if (r_state == WAIT)       r_cnt <= r_cnt + 1;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU: consumes alu_result as the effective address for loads and stores.
- Drives a req/gnt/rvalid data bus with byte enables and lane-aligned write data.
- Returns sign/zero-extended load data to writeback and stalls the core until the access retires.
- Flags misaligned addresses, illegal sizes and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, WAIT-state cycles before bus_error; 0 disables the timeout.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
lsu_req  in  1  memory instruction present; held by core until lsu_done
lsu_we  in  1  1=store, 0=load
lsu_size  in  2  00=byte, 01=half, 10=word, 11=illegal
lsu_unsigned  in  1  1=LBU/LHU zero-extend
alu_result  in  32  effective address
store_data  in  32  rs2 value, right-aligned
lsu_stall  out  1  hold PC/pipeline
lsu_done  out  1  one-cycle retire pulse
load_data  out  32  extended load result, valid with lsu_done
misaligned  out  1  pulse with lsu_done, no bus access made
bus_error  out  1  pulse with lsu_done on timeout
dbus_req  out  1  bus request
dbus_we  out  1  bus write
dbus_addr  out  32  word address, bits[1:0]=00
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-replicated write data
dbus_gnt  in  1  request accepted
dbus_rvalid  in  1  response / write ack
dbus_rdata  in  32  read data

Behaviour:
- Reset (async): state=IDLE. lsu_done, misaligned, bus_error, dbus_req, dbus_we = 0. load_data, dbus_addr, dbus_be, dbus_wdata = 0. Timeout counter = 0.
- lsu_stall = lsu_req & ~lsu_done (combinational). The instruction retires in the done cycle.
- IDLE: accept when lsu_req & ~lsu_done.
  - Misaligned or illegal (size 11; half with addr[0]=1; word with addr[1:0]!=0): no bus activity; next cycle lsu_done=1, misaligned=1, load_data=0.
  - Otherwise: register addr[31:2]<<2, be, wdata, we, size, unsigned and offset addr[1:0]; go to REQ.
- REQ: dbus_req=1 with registered fields.
  - gnt → WAIT, counter cleared.
  - gnt & rvalid in the same cycle → complete directly (see WAIT).
- WAIT: dbus_req=0. Counter increments each cycle.
  - rvalid → IDLE. Next cycle lsu_done=1; for loads, load_data = formatted rdata; for stores, load_data=0.
  - Counter reaches TIMEOUT_CYCLES (non-zero) → IDLE. Next cycle lsu_done=1, bus_error=1, load_data=0.
- Minimum latency: accept cycle N, req N+1, gnt N+1, rvalid N+2, lsu_done N+3.
- Store lanes:
  - Byte: be=0001<<off, wdata={4{d[7:0]}}.
  - Half: be=0011<<off, wdata={2{d[15:0]}}.
  - Word: be=1111, wdata=d.
- Load format: shift rdata right by off*8, then sign- or zero-extend per size and unsigned (word ignores unsigned).
- rvalid or gnt seen in IDLE (e.g. a stale response after reset) is ignored.
- Reset mid-transaction: immediate return to IDLE, dbus_req drops asynchronously, no lsu_done.
- Input changes while not in IDLE are ignored; all fields are registered at accept.

Decomposition:
- lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), state enum (IDLE, REQ, WAIT), funct3-to-size/unsigned mapping constants.
- One sub-module, lsu_align: purely combinational be/wdata generation, load extraction/extension, and misalignment detection. The FSM and counter stay in load_store_unit.

Test Plan:
- LB addr 0x1003, rdata 0x80FF_1234, gnt on first REQ cycle, rvalid next cycle → lsu_done at N+3, load_data=0xFFFF_FF80.
- LHU addr 0x2002, rdata 0x8001_7FFF → load_data=0x0000_8001. Same access as LH → load_data=0xFFFF_8001.
- SB addr 0x3001, store_data 0x0000_00AB → dbus_addr=0x3000, be=0010, wdata=0xABAB_ABAB, dbus_we=1. Ack → lsu_done, load_data=0.
- LW addr 0x4002 → no dbus_req ever; lsu_done=1 and misaligned=1 at N+1; lsu_stall low in that cycle.
- gnt held low 5 cycles then high; TIMEOUT_CYCLES=4 with no rvalid → dbus_req held through REQ; bus_error=1 with lsu_done 5 cycles after gnt.
- Assert rst_n=0 during WAIT, then release and inject stray rvalid → no lsu_done; a following SW completes normally with be=1111.
